// File: rtl/cordic_sincos_iter.sv
// Iterative rotation-mode CORDIC producing cos/sin of a Q3 angle, one micro-rotation per clock.
// Full-circle input via wrap + half-plane fold; gain pre-compensated by starting x at K.
module cordic_sincos_iter #(
    parameter int WIDTH = 16,
    parameter int ITERS = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] theta,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] cos_out,
    output logic signed [WIDTH-1:0] sin_out
);
    localparam int XW = WIDTH + 2;
    localparam int ZW = WIDTH + 1;
    localparam int TW = WIDTH + 2;
    localparam int SH = 32 - WIDTH;

    // Q3.29 / Q2.30 master constants are rounded down to the working precision here.
    function automatic longint rnd_q(input longint v);
        return (v + (longint'(1) <<< (SH - 1))) >>> SH;
    endfunction

    function automatic longint atan_q29(input int i);
        case (i)
            0:       return 64'sd421657428;
            1:       return 64'sd248918915;
            2:       return 64'sd131521918;
            3:       return 64'sd66762580;
            4:       return 64'sd33510843;
            5:       return 64'sd16771757;
            6:       return 64'sd8387926;
            7:       return 64'sd4194218;
            8:       return 64'sd2097141;
            9:       return 64'sd1048575;
            10:      return 64'sd524288;
            11:      return 64'sd262144;
            12:      return 64'sd131072;
            13:      return 64'sd65536;
            14:      return 64'sd32768;
            15:      return 64'sd16384;
            default: return 64'sd0;
        endcase
    endfunction

    function automatic logic signed [WIDTH-1:0] to_out(input logic signed [XW-1:0] v,
                                                       input logic neg);
        return WIDTH'(neg ? -v : v);
    endfunction

    localparam logic signed [TW-1:0] PI_C      = TW'(rnd_q(64'sd1686629713));
    localparam logic signed [TW-1:0] HALF_PI_C = TW'(rnd_q(64'sd843314857));
    localparam logic signed [TW-1:0] TWO_PI_C  = TW'(rnd_q(64'sd3373259426));
    localparam logic signed [XW-1:0] K_C       = XW'(rnd_q(64'sd652032874));

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_ITER, S_DONE} state_t;

    state_t                  r_state, w_state_nxt;
    logic [3:0]              r_cnt;
    logic signed [WIDTH-1:0] r_theta;
    logic signed [XW-1:0]    r_x, r_y;
    logic signed [ZW-1:0]    r_z;
    logic                    r_neg;
    logic signed [WIDTH-1:0] r_cos, r_sin;

    logic signed [ZW-1:0]    w_atan [16];
    logic signed [TW-1:0]    w_ext, w_wrap, w_fold;
    logic                    w_fold_neg;
    logic                    w_dpos, w_last;
    logic signed [XW-1:0]    w_xs, w_ys, w_x_nxt, w_y_nxt;
    logic signed [ZW-1:0]    w_z_nxt;

    for (genvar g = 0; g < 16; g++) begin : g_atan
        assign w_atan[g] = ZW'(rnd_q(atan_q29(g)));
    end

    // PRE: single wrap into [-pi,pi), then fold into [-pi/2,pi/2] with a sign flag
    always_comb begin
        w_ext  = TW'(r_theta);
        w_wrap = w_ext;
        if (w_ext >= PI_C)
            w_wrap = w_ext - TWO_PI_C;
        else if (w_ext < -PI_C)
            w_wrap = w_ext + TWO_PI_C;
        w_fold     = w_wrap;
        w_fold_neg = 1'b0;
        if (w_wrap > HALF_PI_C) begin
            w_fold     = w_wrap - PI_C;
            w_fold_neg = 1'b1;
        end else if (w_wrap < -HALF_PI_C) begin
            w_fold     = w_wrap + PI_C;
            w_fold_neg = 1'b1;
        end
    end

    // ITER: one micro-rotation toward z = 0
    always_comb begin
        w_dpos  = ~r_z[ZW-1];
        w_xs    = r_x >>> r_cnt;
        w_ys    = r_y >>> r_cnt;
        w_x_nxt = w_dpos ? r_x - w_ys : r_x + w_ys;
        w_y_nxt = w_dpos ? r_y + w_xs : r_y - w_xs;
        w_z_nxt = w_dpos ? r_z - w_atan[r_cnt] : r_z + w_atan[r_cnt];
        w_last  = (r_cnt == 4'(ITERS - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    w_state_nxt = S_PRE;
            end
            S_PRE:  w_state_nxt = S_ITER;
            S_ITER: if (w_last) w_state_nxt = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_cos <= '0;
            r_sin <= '0;
        end else begin
            case (r_state)
                S_PRE:  r_cnt <= '0;
                S_ITER: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_last) begin
                        r_cos <= to_out(w_x_nxt, r_neg);
                        r_sin <= to_out(w_y_nxt, r_neg);
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers carry no reset; PRE fully reinitialises them for every angle.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && in_valid)
            r_theta <= theta;
        if (r_state == S_PRE) begin
            r_x   <= K_C;
            r_y   <= '0;
            r_z   <= ZW'(w_fold);
            r_neg <= w_fold_neg;
        end else if (r_state == S_ITER) begin
            r_x <= w_x_nxt;
            r_y <= w_y_nxt;
            r_z <= w_z_nxt;
        end
    end

    assign cos_out = r_cos;
    assign sin_out = r_sin;

endmodule

// File: tb/tb_cordic_sincos_iter.sv
// Bench for cordic_sincos_iter: directed angles, reset, backpressure, and random sweeps at two sizes
// checked against a floating-point sin/cos reference.
module tb_cordic_sincos_iter;
    localparam int AW = 16;
    localparam int AI = 12;
    localparam int BW = 24;
    localparam int BI = 16;
    localparam int A_TOL = 12;
    localparam int B_TOL = 132;
    localparam int A_PI = 25736;
    localparam int B_PI = 6588397;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                 a_in_valid = 1'b0, a_out_ready = 1'b1;
    logic                 a_in_ready, a_out_valid;
    logic signed [AW-1:0] a_theta = '0;
    logic signed [AW-1:0] a_cos, a_sin;

    logic                 b_in_valid = 1'b0, b_out_ready = 1'b1;
    logic                 b_in_ready, b_out_valid;
    logic signed [BW-1:0] b_theta = '0;
    logic signed [BW-1:0] b_cos, b_sin;

    int checks = 0;
    int errors = 0;

    cordic_sincos_iter #(.WIDTH(AW), .ITERS(AI)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .theta(a_theta),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .cos_out(a_cos), .sin_out(a_sin)
    );

    cordic_sincos_iter #(.WIDTH(BW), .ITERS(BI)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .theta(b_theta),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .cos_out(b_cos), .sin_out(b_sin)
    );

    task automatic chk(input string tag, input integer obs, input integer exp, input integer tol);
        checks++;
        assert ((tol == 0) ? (obs === exp) : ((obs - exp <= tol) && (exp - obs <= tol)))
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
        end
    endtask

    // Reference: true sin/cos of the angle the input code represents, scaled to Q2.(w-2).
    function automatic integer model(input integer th, input int w, input bit sine);
        real a, v, s;
        a = real'(th) / (2.0 ** (w - 3));
        v = sine ? $sin(a) : $cos(a);
        s = v * (2.0 ** (w - 2));
        return $rtoi(s >= 0.0 ? s + 0.5 : s - 0.5);
    endfunction

    task automatic a_send(input integer th);
        int n;
        n = 0;
        while (a_in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("a_accept_ready", a_in_ready, 1, 0);
        a_theta    = th[AW-1:0];
        a_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
    endtask

    task automatic a_wait(output int lat);
        lat = 0;
        while (a_out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic a_run(input string tag, input integer th, input integer ec, input integer es);
        int lat;
        a_out_ready = 1'b1;
        a_send(th);
        a_wait(lat);
        chk({tag, "_latency"}, lat, AI + 1, 0);
        chk({tag, "_cos"}, a_cos, ec, A_TOL);
        chk({tag, "_sin"}, a_sin, es, A_TOL);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_valid_drop"}, a_out_valid, 0, 0);
        chk({tag, "_ready_back"}, a_in_ready, 1, 0);
    endtask

    task automatic b_send(input integer th);
        int n;
        n = 0;
        while (b_in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b_accept_ready", b_in_ready, 1, 0);
        b_theta    = th[BW-1:0];
        b_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 1'b0;
    endtask

    int     lat, n, acc, res;
    integer th, hold_c, hold_s;
    bit     seen, done;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", a_in_ready, 1, 0);
        chk("rst_out_valid", a_out_valid, 0, 0);
        chk("rst_cos", a_cos, 0, 0);
        chk("rst_sin", a_sin, 0, 0);
        chk("rst_b_in_ready", b_in_ready, 1, 0);
        chk("rst_b_cos", b_cos, 0, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed angles, including fold and wrap cases
        a_run("zero", 0, 16384, 0);
        a_run("pi6", 4289, 14189, 8192);
        a_run("pi2", 12868, 0, 16384);
        a_run("neg_pi", -25736, -16384, 0);
        a_run("3pi4", 19302, -11585, 11585);
        a_run("wrap", 32767, -10709, -12400);

        // Reset while iterating
        a_send(8000);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", a_out_valid, 0, 0);
        chk("midrst_in_ready", a_in_ready, 1, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (a_out_valid !== 1'b0) seen = 1'b1;
        end
        chk("midrst_no_result", seen, 0, 0);
        a_run("after_rst", 4289, 14189, 8192);

        // Backpressure: result held, second request ignored
        a_out_ready = 1'b0;
        a_send(-4289);
        a_wait(lat);
        chk("bp_latency", lat, AI + 1, 0);
        hold_c = a_cos;
        hold_s = a_sin;
        chk("bp_cos", hold_c, 14189, A_TOL);
        chk("bp_sin", hold_s, -8192, A_TOL);
        a_theta    = 16'sd12868;
        a_in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("bp_valid_held", a_out_valid, 1, 0);
            chk("bp_in_ready_low", a_in_ready, 0, 0);
            chk("bp_cos_stable", a_cos, hold_c, 0);
            chk("bp_sin_stable", a_sin, hold_s, 0);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_valid", a_out_valid, 0, 0);
        chk("bp_release_ready", a_in_ready, 1, 0);
        chk("bp_keep_cos", a_cos, hold_c, 0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (a_out_valid !== 1'b0) seen = 1'b1;
        end
        chk("bp_no_extra_result", seen, 0, 0);

        // Random sweep, WIDTH=16 / ITERS=12, random downstream stalls
        acc = 0;
        res = 0;
        for (int i = 0; i < 1000; i++) begin
            th = integer'($urandom_range(2 * A_PI - 1)) - A_PI;
            a_send(th);
            acc++;
            n    = 0;
            done = 1'b0;
            while (!done && n < 200) begin
                a_out_ready = 1'($urandom_range(1));
                if (a_out_valid === 1'b1 && a_out_ready) begin
                    chk("sweep_a_cos", a_cos, model(th, AW, 1'b0), A_TOL);
                    chk("sweep_a_sin", a_sin, model(th, AW, 1'b1), A_TOL);
                    res++;
                    @(posedge clk);
                    @(negedge clk);
                    chk("sweep_a_single", a_out_valid, 0, 0);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                    n++;
                end
            end
            if (!done) chk("sweep_a_timeout", a_out_valid, 1, 0);
        end
        chk("sweep_a_count", res, acc, 0);

        // Random sweep, WIDTH=24 / ITERS=16
        acc = 0;
        res = 0;
        for (int i = 0; i < 300; i++) begin
            th = integer'($urandom_range(2 * B_PI - 1)) - B_PI;
            b_send(th);
            acc++;
            n    = 0;
            done = 1'b0;
            while (!done && n < 200) begin
                b_out_ready = 1'($urandom_range(1));
                if (b_out_valid === 1'b1 && b_out_ready) begin
                    chk("sweep_b_cos", b_cos, model(th, BW, 1'b0), B_TOL);
                    chk("sweep_b_sin", b_sin, model(th, BW, 1'b1), B_TOL);
                    res++;
                    @(posedge clk);
                    @(negedge clk);
                    chk("sweep_b_single", b_out_valid, 0, 0);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                    n++;
                end
            end
            if (!done) chk("sweep_b_timeout", b_out_valid, 1, 0);
        end
        chk("sweep_b_count", res, acc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
